// File: rtl/exec_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus iterative shift and multiply.
// Define EXEC_MUL_EN to build the shift-add multiplier; otherwise MUL retires without a write.
module exec_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              reg_wr_en,
    output logic              busy,
    output logic              flag_zero,
    output logic              flag_carry
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;
    localparam int unsigned CNT_W = ($clog2(DATA_W + 1) > 3) ? $clog2(DATA_W + 1) : 4;

    typedef enum logic [1:0] {StIdle, StIter, StWb} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_wb_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_flag_zero;
    logic                r_flag_carry;

    logic                w_accept;
    logic                w_goes_iter;
    logic                w_wb_en_in;
    logic                w_last_iter;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_cy;
    logic [DATA_W-1:0]   w_shl_nxt;
    logic                w_load;
    logic [DATA_W-1:0]   w_res;
    logic                w_cy;
    logic [ADDR_W-1:0]   w_load_addr;

`ifdef EXEC_MUL_EN
    logic                r_is_mul;
    logic [DATA_W-1:0]   r_b;
    logic [2*DATA_W-1:0] r_mcand;
    logic [2*DATA_W-1:0] r_prod;
    logic [2*DATA_W-1:0] w_prod_nxt;

    assign w_goes_iter = (op == OP_MUL) || ((op == OP_SHL) && (b[2:0] != 3'd0));
    assign w_wb_en_in  = 1'b1;
    assign w_prod_nxt  = r_b[0] ? (r_prod + r_mcand) : r_prod;
`else
    assign w_goes_iter = (op == OP_SHL) && (b[2:0] != 3'd0);
    // Without the multiplier, MUL still passes through WB but never writes.
    assign w_wb_en_in  = (op != OP_MUL);
`endif

    assign w_accept    = in_valid && (r_state == StIdle);
    assign w_last_iter = (r_state == StIter) && (r_cnt == CNT_W'(1));
    assign w_shl_nxt   = r_acc << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_nxt = w_goes_iter ? StIter : StWb;
            StIter: if (w_last_iter) w_state_nxt = StWb;
            StWb:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        busy      = (r_state != StIdle);
        reg_wr_en = (r_state == StWb) && r_wb_en;
    end

    always_comb begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_alu_res = '0;
        w_alu_cy  = 1'b0;
        unique case (op)
            OP_ADD: begin w_alu_res = w_sum[DATA_W-1:0];  w_alu_cy = w_sum[DATA_W];  end
            OP_SUB: begin w_alu_res = w_diff[DATA_W-1:0]; w_alu_cy = w_diff[DATA_W]; end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_SHL: w_alu_res = a;
            OP_MUL: w_alu_res = '0;
            OP_MOV: w_alu_res = b;
            default: w_alu_res = '0;
        endcase
    end

    // Output registers load on the edge that enters WB, from the ALU or the iterator.
    always_comb begin
        w_load      = 1'b0;
        w_res       = r_wr_data;
        w_cy        = r_flag_carry;
        w_load_addr = r_rd;
        if (w_accept && !w_goes_iter) begin
            w_load      = w_wb_en_in;
            w_res       = w_alu_res;
            w_cy        = w_alu_cy;
            w_load_addr = rd_addr;
        end else if (w_last_iter) begin
            w_load = 1'b1;
`ifdef EXEC_MUL_EN
            if (r_is_mul) begin
                w_res = w_prod_nxt[DATA_W-1:0];
                w_cy  = |w_prod_nxt[2*DATA_W-1:DATA_W];
            end else begin
                w_res = w_shl_nxt;
                w_cy  = r_acc[DATA_W-1];
            end
`else
            w_res = w_shl_nxt;
            w_cy  = r_acc[DATA_W-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_rd         <= '0;
            r_wb_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
`ifdef EXEC_MUL_EN
            r_is_mul     <= 1'b0;
            r_b          <= '0;
            r_mcand      <= '0;
            r_prod       <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_acc   <= a;
                r_rd    <= rd_addr;
                r_wb_en <= w_wb_en_in;
`ifdef EXEC_MUL_EN
                r_cnt    <= (op == OP_MUL) ? CNT_W'(DATA_W) : CNT_W'(b[2:0]);
                r_is_mul <= (op == OP_MUL);
                r_b      <= b;
                r_mcand  <= {{DATA_W{1'b0}}, a};
                r_prod   <= '0;
`else
                r_cnt    <= CNT_W'(b[2:0]);
`endif
            end else if (r_state == StIter) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_acc <= w_shl_nxt;
`ifdef EXEC_MUL_EN
                r_prod  <= w_prod_nxt;
                r_mcand <= r_mcand << 1;
                r_b     <= r_b >> 1;
`endif
            end
            if (w_load) begin
                r_wr_addr    <= w_load_addr;
                r_wr_data    <= w_res;
                r_flag_zero  <= (w_res == '0);
                r_flag_carry <= w_cy;
            end
        end
    end

    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign flag_zero  = r_flag_zero;
    assign flag_carry = r_flag_carry;

endmodule

// File: tb/tb_exec_unit.sv
// Directed, table-driven bench for exec_unit; MUL vectors only when EXEC_MUL_EN is defined.
module tb_exec_unit;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [1:0] rd_addr;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       reg_wr_en;
    logic       busy;
    logic       flag_zero;
    logic       flag_carry;

    int total = 0;
    int bad   = 0;

    exec_unit #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd_addr    (rd_addr),
        .a          (a),
        .b          (b),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .reg_wr_en  (reg_wr_en),
        .busy       (busy),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] rd;
        logic [7:0] d;
        logic       z;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one op from an idle unit, then wait for the write pulse and check it.
    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        op = v.op; a = v.a; b = v.b; rd_addr = v.rd;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; rd_addr = ~v.rd;
        check({v.name, " busy"}, int'(busy), 1);
        n = 1;
        while (!reg_wr_en && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({v.name, " latency"}, n, v.lat);
        check({v.name, " wr_data"}, int'(wr_data), int'(v.d));
        check({v.name, " wr_addr"}, int'(wr_addr), int'(v.rd));
        check({v.name, " zero"}, int'(flag_zero), int'(v.z));
        check({v.name, " carry"}, int'(flag_carry), int'(v.c));
        @(negedge clk);
        check({v.name, " pulse len"}, int'(reg_wr_en), 0);
    endtask

    initial begin
        int pulses;
        reset = 1'b0; in_valid = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0; rd_addr = 2'd0;

        vecs.push_back('{"add",    3'b000, 8'hF0, 8'h20, 2'd2, 8'h10, 1'b0, 1'b1, 1});
        vecs.push_back('{"sub eq", 3'b001, 8'h05, 8'h05, 2'd1, 8'h00, 1'b1, 1'b0, 1});
        vecs.push_back('{"sub lt", 3'b001, 8'h03, 8'h05, 2'd3, 8'hFE, 1'b0, 1'b1, 1});
        vecs.push_back('{"and",    3'b010, 8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0, 1'b0, 1});
        vecs.push_back('{"or",     3'b011, 8'h0F, 8'h30, 2'd1, 8'h3F, 1'b0, 1'b0, 1});
        vecs.push_back('{"xor",    3'b100, 8'hAA, 8'hAA, 2'd2, 8'h00, 1'b1, 1'b0, 1});
        vecs.push_back('{"mov",    3'b111, 8'h12, 8'h77, 2'd3, 8'h77, 1'b0, 1'b0, 1});
        vecs.push_back('{"shl3",   3'b101, 8'h81, 8'h03, 2'd1, 8'h08, 1'b0, 1'b0, 4});
        vecs.push_back('{"shl0",   3'b101, 8'h81, 8'h00, 2'd2, 8'h81, 1'b0, 1'b0, 1});
        vecs.push_back('{"shl1",   3'b101, 8'h81, 8'h01, 2'd0, 8'h02, 1'b0, 1'b1, 2});
        vecs.push_back('{"shl7",   3'b101, 8'h01, 8'h07, 2'd3, 8'h80, 1'b0, 1'b0, 8});
        vecs.push_back('{"shl msk",3'b101, 8'hC0, 8'hF9, 2'd1, 8'h80, 1'b0, 1'b1, 2});
`ifdef EXEC_MUL_EN
        vecs.push_back('{"mul 12x11", 3'b110, 8'd12,  8'd11,  2'd2, 8'h84, 1'b0, 1'b0, 9});
        vecs.push_back('{"mul 16x32", 3'b110, 8'd16,  8'd32,  2'd3, 8'h00, 1'b1, 1'b1, 9});
        vecs.push_back('{"mul ffxff", 3'b110, 8'hFF,  8'hFF,  2'd1, 8'h01, 1'b0, 1'b1, 9});
`endif

        #1;
        check("rst in_ready", int'(in_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst wr_en", int'(reg_wr_en), 0);
        check("rst wr_data", int'(wr_data), 0);
        check("rst wr_addr", int'(wr_addr), 0);
        check("rst flags", int'({flag_zero, flag_carry}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

`ifndef EXEC_MUL_EN
        // MUL without the multiplier: accepted, no write, outputs and flags untouched.
        run_vec('{"add pre", 3'b000, 8'hF0, 8'h20, 2'd2, 8'h10, 1'b0, 1'b1, 1});
        @(negedge clk);
        in_valid = 1'b1; op = 3'b110; a = 8'd12; b = 8'd11; rd_addr = 2'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("nomul in_ready wb", int'(in_ready), 0);
        check("nomul wr_en", int'(reg_wr_en), 0);
        @(negedge clk);
        check("nomul in_ready idle", int'(in_ready), 1);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (reg_wr_en) pulses++;
        end
        check("nomul pulses", pulses, 0);
        check("nomul wr_data", int'(wr_data), 8'h10);
        check("nomul wr_addr", int'(wr_addr), 2);
        check("nomul flags", int'({flag_zero, flag_carry}), 1);
`endif

        // in_valid held high: accepts every other cycle, operand changes while busy ignored.
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("thru in_ready k%0d", k), int'(in_ready), (k % 2 == 0) ? 1 : 0);
            check($sformatf("thru wr_en k%0d", k), int'(reg_wr_en), (k % 2 == 1) ? 1 : 0);
            if (k == 1) check("thru d0", int'(wr_data), 8'h03);
            if (k == 3) check("thru d1", int'(wr_data), 8'h1E);
            if (k == 5) begin
                check("thru d2", int'(wr_data), 8'h00);
                check("thru d2 flags", int'({flag_zero, flag_carry}), 3);
            end
            in_valid = 1'b1; op = 3'b000; rd_addr = 2'(k);
            case (k)
                0: begin a = 8'h01; b = 8'h02; end
                2: begin a = 8'h0A; b = 8'h14; end
                4: begin a = 8'hFF; b = 8'h01; end
                default: begin a = 8'h77; b = 8'h66; end
            endcase
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset three cycles into a long op: result discarded, no write issued.
        in_valid = 1'b1; rd_addr = 2'd3;
`ifdef EXEC_MUL_EN
        op = 3'b110; a = 8'd12; b = 8'd11;
`else
        op = 3'b101; a = 8'h01; b = 8'h07;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid rst in_ready", int'(in_ready), 1);
        check("mid rst busy", int'(busy), 0);
        check("mid rst wr_data", int'(wr_data), 0);
        check("mid rst flags", int'({flag_zero, flag_carry}), 0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (reg_wr_en) pulses++;
        end
        check("mid rst pulses", pulses, 0);
        check("post rst in_ready", int'(in_ready), 1);
        run_vec('{"add after rst", 3'b000, 8'h01, 8'h01, 2'd1, 8'h02, 1'b0, 1'b0, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
